exc_ctrl_seq: RTL and testbench
===============================

# exc_ctrl_seq

Sequential, parametrised exception/interrupt controller for the commit stage of the MIPS pipeline. It samples exception causes once per committing instruction and applies fixed MIPS priority. It then runs a flush/redirect state machine that drives CP0 update strobes, holds the pipeline flush for a configurable number of cycles, and issues a single-cycle redirect to the handler or to EPC. It adds masked, latched interrupt lines, nested-exception (EXL) handling and an exception counter.

## Interface
- NUM_IRQ, 8, number of interrupt lines (2..8; lines 0..1 are software interrupts)
- FLUSH_CYCLES, 2, cycles flush stays high (1..15)
- BOOT_BASE, 32'hBFC00200, exception base when boot_vec=1
- CNT_W, 16, width of exc_count
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- commit_valid  in  1  an instruction is in the commit stage this cycle
- invalid_inst, syscall, break_inst, eret, overflow  in  1 each  per-instruction cause flags
- iaddr_err  in  1  fetch address error; daddr_err  in  1  data address error; daddr_we  in  1  1 = store
- pc  in  32  PC of the committing instruction; mem_vaddr  in  32  faulting data address
- in_delayslot  in  1  committing instruction is in a branch delay slot
- irq  in  NUM_IRQ  level interrupt requests; irq_mask  in  NUM_IRQ  Status.IM
- status_ie, status_exl, status_erl  in  1 each  Status bits
- ebase  in  20  EBase[31:12]; epc_in  in  32  current EPC; cause_iv  in  1  Cause.IV; boot_vec  in  1  Status.BEV
- busy  out  1  controller not in IDLE; commit stage must stall
- flush  out  1  clear IF..MEM
- redirect_valid  out  1  one-cycle strobe; redirect_pc  out  32  new PC
- cp0_wr_exp  out  1  one-cycle exception strobe; exp_epc_we  out  1  write EPC/Cause.BD
- cp0_clean_exl  out  1  one-cycle strobe on ERET
- exp_code  out  5; exp_epc  out  32; exp_bd  out  1
- exp_badvaddr  out  32; cp0_badv_we  out  1
- irq_pending  out  NUM_IRQ  latched, masked view of irq
- exc_count  out  CNT_W  number of exceptions taken (ERET is not counted)

## Operation
- irq_pending is registered every cycle as irq & irq_mask. It is level-based and never sticky.
- Interrupt eligibility: status_ie=1, status_exl=0, status_erl=0, irq_pending≠0, and invalid_inst=0.
- A trigger occurs when state=IDLE, commit_valid=1, and any cause or eligible interrupt is present.
- Priority, highest first, with codes:
  - Int 0x00
  - iaddr_err AdEL 0x04 (badvaddr=pc)
  - invalid_inst 0x0A
  - overflow 0x0C
  - syscall 0x08
  - break_inst 0x09
  - daddr_err 0x05 if daddr_we else 0x04 (badvaddr=mem_vaddr)
  - eret (not an exception)
- On trigger, the cause, pc, mem_vaddr, in_delayslot, status_exl, epc_in, base and vector are captured. All inputs are ignored outside IDLE.
- base = boot_vec ? BOOT_BASE : {ebase,12'h0}. Vector = base+0x200 for Int with cause_iv=1, otherwise base+0x180. ERET target = captured epc_in.
- exp_epc = in_delayslot ? pc-4 : pc, 32-bit wrap. exp_bd = in_delayslot.
- Nested exception: if captured status_exl=1, exp_epc_we=0 while cp0_wr_exp still pulses. Otherwise exp_epc_we pulses with cp0_wr_exp.
- FSM states:
  - IDLE -> FLUSH on trigger.
  - FLUSH holds for FLUSH_CYCLES cycles, then -> REDIRECT.
  - REDIRECT lasts 1 cycle, then -> IDLE.
- ERET follows the same path but pulses cp0_clean_exl instead of cp0_wr_exp/exp_epc_we/cp0_badv_we, and exp_code=0.
- exc_count increments by 1 per non-ERET trigger and saturates at all-ones.
- exp_code, exp_epc, exp_bd and exp_badvaddr hold their last values until the next trigger. exp_badvaddr is only updated for address errors.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE and every output is 0, including irq_pending, exc_count, exp_* and redirect_pc.
- Reset asserted mid-sequence aborts it at that edge. No redirect and no strobe is produced afterwards.
- Trigger sampled at edge T:
  - busy=1 and flush=1 from T+1 through T+FLUSH_CYCLES.
  - cp0_wr_exp, exp_epc_we, cp0_badv_we or cp0_clean_exl pulse only in cycle T+1.
  - redirect_valid=1 in cycle T+FLUSH_CYCLES+1, with busy=1 and flush=0.
  - IDLE from T+FLUSH_CYCLES+2; a new trigger can be accepted at that edge.
- Interrupt latency: irq rising at edge E is visible in irq_pending after E, and can be taken at the next commit edge ≥E+1.
- Simultaneous causes: only the highest-priority cause is reported. An interrupt pre-empts eret.

## Test plan
- Syscall: pc=0x80001000, in_delayslot=0, ebase=0x80000, boot_vec=0.
  - Response: exp_code=0x08, exp_epc=0x80001000 at T+1; flush at T+1..T+2; redirect_pc=0x80000180 at T+3; exc_count=1.
- Delay-slot overflow: pc=0x80002004, in_delayslot=1.
  - Response: exp_epc=0x80002000, exp_bd=1, exp_code=0x0C.
- Interrupt: irq=0x04, irq_mask=0x04, ie=1, exl=0, cause_iv=1, boot_vec=1, with syscall also set.
  - Response: exp_code=0x00, redirect_pc=0xBFC00400.
- Masked interrupt: irq_mask=0 or status_exl=1.
  - Response: no trigger, busy stays 0. A concurrent daddr_err store with exl=1 gives exp_code=0x05, badvaddr=mem_vaddr, cp0_badv_we=1, exp_epc_we=0.
- ERET: epc_in=0x80003000.
  - Response: cp0_clean_exl pulse, cp0_wr_exp=0, redirect_pc=0x80003000, exc_count unchanged. A second trigger presented while busy is ignored.
- Reset pulled at T+2 of a sequence.
  - Response: all outputs 0 at T+3, no redirect_valid ever asserted.

Source files
------------

// File: rtl/exc_ctrl_seq.sv
// exc_ctrl_seq: commit-stage exception/interrupt controller for the MIPS pipeline.
// An instruction at commit is checked for exception causes and eligible interrupts,
// and the highest-priority one is picked. A trigger runs the flush/redirect sequence:
//   IDLE -> FLUSH (FLUSH_CYCLES cycles) -> REDIRECT (1 cycle) -> IDLE.
// CP0 update strobes pulse in the first FLUSH cycle. The redirect strobe fires in the
// REDIRECT cycle. ERET takes the same path and returns to the EPC captured at the trigger.
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   commit_valid + cause flags   committing instruction and its exception causes
//   pc, mem_vaddr, in_delayslot  context captured on a trigger
//   irq, irq_mask                interrupt lines and Status.IM
//   status_*, ebase, epc_in,
//   cause_iv, boot_vec           CP0 state used for eligibility and the vector
//   busy, flush                  pipeline stall / clear
//   redirect_valid, redirect_pc  one-cycle PC redirect
//   cp0_* / exp_*                CP0 update strobes and captured values
//   irq_pending, exc_count       masked interrupt view, count of exceptions taken
module exc_ctrl_seq #(
   parameter int          NUM_IRQ      = 8,
   parameter int          FLUSH_CYCLES = 2,
   parameter logic [31:0] BOOT_BASE    = 32'hBFC00200,
   parameter int          CNT_W        = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               commit_valid,
   input  logic               invalid_inst,
   input  logic               syscall,
   input  logic               break_inst,
   input  logic               eret,
   input  logic               overflow,
   input  logic               iaddr_err,
   input  logic               daddr_err,
   input  logic               daddr_we,
   input  logic [31:0]        pc,
   input  logic [31:0]        mem_vaddr,
   input  logic               in_delayslot,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic [NUM_IRQ-1:0] irq_mask,
   input  logic               status_ie,
   input  logic               status_exl,
   input  logic               status_erl,
   input  logic [19:0]        ebase,
   input  logic [31:0]        epc_in,
   input  logic               cause_iv,
   input  logic               boot_vec,
   output logic               busy,
   output logic               flush,
   output logic               redirect_valid,
   output logic [31:0]        redirect_pc,
   output logic               cp0_wr_exp,
   output logic               exp_epc_we,
   output logic               cp0_clean_exl,
   output logic [4:0]         exp_code,
   output logic [31:0]        exp_epc,
   output logic               exp_bd,
   output logic [31:0]        exp_badvaddr,
   output logic               cp0_badv_we,
   output logic [NUM_IRQ-1:0] irq_pending,
   output logic [CNT_W-1:0]   exc_count
);

   typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

   localparam logic [3:0] FC = 4'(FLUSH_CYCLES);

   state_t      state;
   logic [3:0]  fcnt;
   logic [31:0] target_q;   // handler vector or ERET return address

   // cause decode (fixed MIPS priority)
   logic        int_ok, is_eret, is_badv, trig;
   logic [4:0]  code;
   logic [31:0] badv, base, target;

   // Interrupts are taken from the registered, masked lines, so an irq edge is
   // visible one cycle later. An invalid instruction blocks interrupt entry.
   assign int_ok = status_ie & ~status_exl & ~status_erl & (|irq_pending) & ~invalid_inst;

   always_comb begin
      code    = 5'h00;
      is_eret = 1'b0;
      is_badv = 1'b0;
      badv    = pc;
      if (int_ok) begin
         code = 5'h00;
      end else if (iaddr_err) begin
         code    = 5'h04;
         is_badv = 1'b1;
      end else if (invalid_inst) begin
         code = 5'h0A;
      end else if (overflow) begin
         code = 5'h0C;
      end else if (syscall) begin
         code = 5'h08;
      end else if (break_inst) begin
         code = 5'h09;
      end else if (daddr_err) begin
         code    = daddr_we ? 5'h05 : 5'h04;
         is_badv = 1'b1;
         badv    = mem_vaddr;
      end else if (eret) begin
         is_eret = 1'b1;
      end
   end

   assign trig = (state == IDLE) & commit_valid &
                 (int_ok | iaddr_err | invalid_inst | overflow | syscall |
                  break_inst | daddr_err | eret);

   assign base   = boot_vec ? BOOT_BASE : {ebase, 12'h000};
   assign target = is_eret              ? epc_in :
                   (int_ok && cause_iv) ? base + 32'h200 :
                                          base + 32'h180;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         fcnt           <= '0;
         target_q       <= '0;
         busy           <= 1'b0;
         flush          <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         cp0_wr_exp     <= 1'b0;
         exp_epc_we     <= 1'b0;
         cp0_clean_exl  <= 1'b0;
         cp0_badv_we    <= 1'b0;
         exp_code       <= '0;
         exp_epc        <= '0;
         exp_bd         <= 1'b0;
         exp_badvaddr   <= '0;
         irq_pending    <= '0;
         exc_count      <= '0;
      end else begin
         irq_pending    <= irq & irq_mask;
         // strobes are single-cycle by default
         cp0_wr_exp     <= 1'b0;
         exp_epc_we     <= 1'b0;
         cp0_clean_exl  <= 1'b0;
         cp0_badv_we    <= 1'b0;
         redirect_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (trig) begin
                  state    <= FLUSH;
                  fcnt     <= 4'd1;
                  busy     <= 1'b1;
                  flush    <= 1'b1;
                  target_q <= target;
                  exp_code <= code;
                  exp_epc  <= in_delayslot ? pc - 32'd4 : pc;
                  exp_bd   <= in_delayslot;
                  if (is_eret) begin
                     cp0_clean_exl <= 1'b1;
                  end else begin
                     cp0_wr_exp <= 1'b1;
                     // nested exception keeps the original EPC
                     exp_epc_we <= ~status_exl;
                     if (is_badv) begin
                        cp0_badv_we  <= 1'b1;
                        exp_badvaddr <= badv;
                     end
                     if (exc_count != '1)
                        exc_count <= exc_count + 1'b1;
                  end
               end
            end
            FLUSH: begin
               if (fcnt == FC) begin
                  state          <= REDIRECT;
                  flush          <= 1'b0;
                  redirect_valid <= 1'b1;
                  redirect_pc    <= target_q;
               end else begin
                  fcnt <= fcnt + 4'd1;
               end
            end
            REDIRECT: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               flush <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exc_ctrl_seq.sv
// Scoreboard bench for exc_ctrl_seq. The stimulus pushes the expected CP0 strobe
// record and redirect record before each trigger. A negedge monitor pops and
// compares them whenever the DUT raises a strobe or redirect_valid.
module tb_exc_ctrl_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        commit_valid, invalid_inst, syscall, break_inst, eret, overflow;
   logic        iaddr_err, daddr_err, daddr_we, in_delayslot;
   logic [31:0] pc, mem_vaddr, epc_in;
   logic [7:0]  irq, irq_mask;
   logic        status_ie, status_exl, status_erl, cause_iv, boot_vec;
   logic [19:0] ebase;
   logic        busy, flush, redirect_valid, cp0_wr_exp, exp_epc_we, cp0_clean_exl;
   logic        exp_bd, cp0_badv_we;
   logic [31:0] redirect_pc, exp_epc, exp_badvaddr;
   logic [4:0]  exp_code;
   logic [7:0]  irq_pending;
   logic [15:0] exc_count;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [4:0]  code;
      logic [31:0] epc;
      logic        bd, wr, epc_we, badv_we, clean, chk_epc, chk_badv;
      logic [31:0] badv;
   } exp_t;

   typedef struct {
      logic [31:0] pc;
      logic [15:0] count;
   } redir_t;

   exp_t   exp_q[$];
   redir_t redir_q[$];
   exp_t   me;
   redir_t mr;

   exc_ctrl_seq #(.NUM_IRQ(8), .FLUSH_CYCLES(2), .BOOT_BASE(32'hBFC00200), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .commit_valid(commit_valid),
      .invalid_inst(invalid_inst), .syscall(syscall), .break_inst(break_inst),
      .eret(eret), .overflow(overflow), .iaddr_err(iaddr_err),
      .daddr_err(daddr_err), .daddr_we(daddr_we), .pc(pc), .mem_vaddr(mem_vaddr),
      .in_delayslot(in_delayslot), .irq(irq), .irq_mask(irq_mask),
      .status_ie(status_ie), .status_exl(status_exl), .status_erl(status_erl),
      .ebase(ebase), .epc_in(epc_in), .cause_iv(cause_iv), .boot_vec(boot_vec),
      .busy(busy), .flush(flush), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .cp0_wr_exp(cp0_wr_exp), .exp_epc_we(exp_epc_we),
      .cp0_clean_exl(cp0_clean_exl), .exp_code(exp_code), .exp_epc(exp_epc),
      .exp_bd(exp_bd), .exp_badvaddr(exp_badvaddr), .cp0_badv_we(cp0_badv_we),
      .irq_pending(irq_pending), .exc_count(exc_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // monitor
   always @(negedge clk) begin
      if (cp0_wr_exp || cp0_clean_exl) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_cp0_strobe", {cp0_wr_exp, cp0_clean_exl}, 32'h0);
         end else begin
            me = exp_q.pop_front();
            chk("exp_code",      exp_code,      me.code);
            chk("cp0_wr_exp",    cp0_wr_exp,    me.wr);
            chk("cp0_clean_exl", cp0_clean_exl, me.clean);
            chk("exp_epc_we",    exp_epc_we,    me.epc_we);
            chk("cp0_badv_we",   cp0_badv_we,   me.badv_we);
            chk("flush_t1",      flush,         1'b1);
            if (me.chk_epc) begin
               chk("exp_epc", exp_epc, me.epc);
               chk("exp_bd",  exp_bd,  me.bd);
            end
            if (me.chk_badv) chk("exp_badvaddr", exp_badvaddr, me.badv);
         end
      end
      if (redirect_valid) begin
         if (redir_q.size() == 0) begin
            chk("unexpected_redirect", redirect_valid, 1'b0);
         end else begin
            mr = redir_q.pop_front();
            chk("redirect_pc",     redirect_pc, mr.pc);
            chk("exc_count",       exc_count,   mr.count);
            chk("busy_at_redir",   busy,        1'b1);
            chk("flush_at_redir",  flush,       1'b0);
         end
      end
   end

   task automatic clear_causes();
      commit_valid = 0; invalid_inst = 0; syscall = 0; break_inst = 0; eret = 0;
      overflow = 0; iaddr_err = 0; daddr_err = 0; daddr_we = 0; in_delayslot = 0;
   endtask

   // present the prepared causes for one commit edge; returns 1ns into cycle T+1
   task automatic fire();
      commit_valid = 1;
      @(posedge clk); #1;
      clear_causes();
   endtask

   task automatic wait_idle();
      logic done;
      done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(posedge clk); #1;
         if (!busy) done = 1;
      end
      chk("idle_timeout", {31'h0, done}, 32'h1);
   endtask

   task automatic push(input logic [4:0] code, input logic [31:0] epc, input logic bd,
                       input logic wr, input logic epc_we, input logic badv_we,
                       input logic clean, input logic chk_epc, input logic chk_badv,
                       input logic [31:0] badv);
      exp_t e;
      e.code = code; e.epc = epc; e.bd = bd; e.wr = wr; e.epc_we = epc_we;
      e.badv_we = badv_we; e.clean = clean; e.chk_epc = chk_epc;
      e.chk_badv = chk_badv; e.badv = badv;
      exp_q.push_back(e);
   endtask

   task automatic push_r(input logic [31:0] rpc, input logic [15:0] cnt);
      redir_t r;
      r.pc = rpc; r.count = cnt;
      redir_q.push_back(r);
   endtask

   initial begin
      clear_causes();
      rst_n = 0; pc = 0; mem_vaddr = 0; epc_in = 0; irq = 0; irq_mask = 0;
      status_ie = 0; status_exl = 0; status_erl = 0; cause_iv = 0; boot_vec = 0;
      ebase = 20'h80000;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy",        busy,           1'b0);
      chk("rst_flush",       flush,          1'b0);
      chk("rst_redirect_pc", redirect_pc,    32'h0);
      chk("rst_exc_count",   exc_count,      16'h0);
      chk("rst_exp_code",    exp_code,       5'h0);
      chk("rst_irq_pending", irq_pending,    8'h0);
      rst_n = 1;
      @(posedge clk); #1;

      // syscall, flush timing checked explicitly
      pc = 32'h80001000; syscall = 1;
      push(5'h08, 32'h80001000, 0, 1, 1, 0, 0, 1, 0, 0);
      push_r(32'h80000180, 16'd1);
      fire();
      chk("sys_flush_t1", {busy, flush}, 2'b11);
      @(posedge clk); #1;
      chk("sys_flush_t2", {busy, flush}, 2'b11);
      @(posedge clk); #1;
      chk("sys_redir_t3", {redirect_valid, flush}, 2'b10);
      wait_idle();

      // overflow in delay slot
      pc = 32'h80002004; in_delayslot = 1; overflow = 1;
      push(5'h0C, 32'h80002000, 1, 1, 1, 0, 0, 1, 0, 0);
      push_r(32'h80000180, 16'd2);
      fire();
      wait_idle();

      // interrupt pre-empts a concurrent syscall, IV vector from boot base
      irq = 8'h04; irq_mask = 8'h04; status_ie = 1; cause_iv = 1; boot_vec = 1;
      @(posedge clk); #1;
      pc = 32'h80004000; syscall = 1;
      push(5'h00, 32'h80004000, 0, 1, 1, 0, 0, 1, 0, 0);
      push_r(32'hBFC00400, 16'd3);
      fire();
      wait_idle();
      cause_iv = 0; boot_vec = 0;

      // masked interrupt: no trigger
      irq_mask = 8'h00;
      @(posedge clk); #1;
      chk("masked_pending", irq_pending, 8'h00);
      commit_valid = 1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("masked_busy", busy, 1'b0);
      end
      commit_valid = 0;
      // EXL blocks the interrupt
      irq_mask = 8'h04; status_exl = 1;
      @(posedge clk); #1;
      chk("exl_pending", irq_pending, 8'h04);
      commit_valid = 1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("exl_busy", busy, 1'b0);
      end
      commit_valid = 0;
      // nested data-address store error
      pc = 32'h80005000; mem_vaddr = 32'h12345678; daddr_err = 1; daddr_we = 1;
      push(5'h05, 32'h80005000, 0, 1, 0, 1, 0, 0, 1, 32'h12345678);
      push_r(32'h80000180, 16'd4);
      fire();
      wait_idle();
      irq = 0; status_exl = 0; status_ie = 0;

      // fetch address error outranks invalid instruction
      pc = 32'h80006001; iaddr_err = 1; invalid_inst = 1;
      push(5'h04, 32'h80006001, 0, 1, 1, 1, 0, 1, 1, 32'h80006001);
      push_r(32'h80000180, 16'd5);
      fire();
      wait_idle();

      // ERET, with a syscall presented while busy
      epc_in = 32'h80003000; pc = 32'h80007000; eret = 1; status_exl = 1;
      push(5'h00, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      push_r(32'h80003000, 16'd5);
      fire();
      syscall = 1; commit_valid = 1;
      repeat (2) @(posedge clk);
      #1;
      clear_causes();
      wait_idle();
      status_exl = 0;
      chk("eret_count", exc_count, 16'd5);

      // reset in the middle of a sequence
      pc = 32'h80008000; break_inst = 1;
      push(5'h09, 32'h80008000, 0, 1, 1, 0, 0, 1, 0, 0);
      fire();
      @(posedge clk); #1;
      rst_n = 0;
      @(posedge clk); #1;
      chk("mid_rst_busy",  {busy, flush, redirect_valid}, 3'b000);
      chk("mid_rst_count", exc_count, 16'h0);
      chk("mid_rst_code",  exp_code,  5'h0);
      chk("mid_rst_epc",   exp_epc,   32'h0);
      @(posedge clk); #1;
      rst_n = 1;
      repeat (10) @(posedge clk);
      #1;

      chk("exp_q_empty",   exp_q.size(),   32'h0);
      chk("redir_q_empty", redir_q.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
